pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, taken branches resolved in EX, I-side fetch wait and D-side cache-miss wait.
- Drives per-stage enable and NOP-flush controls.
- Tracks D-side wait length and flags a timeout so coherence-protocol hangs are visible.

Parameters:
- REG_W, 5, register-index width.
- FLUSH_CYCLES, 1, cycles of IF/ID + ID/EX flush after a taken branch (>=1).
- TIMEOUT, 255, D-side wait cycles before mem_timeout sets (>=1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- id_rs1  in  REG_W  source reg 1 of the instruction in ID.
- id_rs2  in  REG_W  source reg 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage has an outstanding D-cache access.
- dmem_ready  in  1  D-cache completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage load enables.
- ifid_flush, idex_flush  out  1 each  load NOP (32'h00000013) or bubble instead of next value.
- mem_timeout  out  1  sticky D-side timeout flag.
- stall_cycles, flush_events  out  32 each  perf counters (see Optional Feature).

Behaviour:
- Outputs are combinational from state plus current inputs; state and counters are registered.
- Reset asserted:
  - all *_en = 0; ifid_flush = idex_flush = 1.
  - next cycle: state RUN, flush/wait counters 0, mem_timeout 0.
  - Reset mid-DWAIT/FLUSH returns to RUN with no release cycle.
- States: RUN, FLUSH, DWAIT; DWAIT also records its return state (RUN or FLUSH).
- Load-use hazard: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, priority highest first:
  - dmem_req & !dmem_ready: all *_en = 0, flushes 0; next DWAIT (ret=RUN); wait_cnt <= 1.
  - ex_branch_taken: all *_en = 1; ifid_flush = idex_flush = 1; next FLUSH with flush_cnt = FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay RUN.
  - load-use: pc_en = ifid_en = 0; idex_en = 1, idex_flush = 1; exmem_en = memwb_en = 1. One-cycle bubble; hazard clears naturally next cycle.
  - !imem_ready: pc_en = 0; ifid_en = 1, ifid_flush = 1; others en = 1.
  - else: all en = 1, flushes 0.
- FLUSH:
  - Same D-side freeze rule first: next DWAIT (ret=FLUSH); flush_cnt held.
  - Otherwise: pc_en = imem_ready; ifid_en = idex_en = exmem_en = memwb_en = 1; ifid_flush = idex_flush = 1.
  - flush_cnt decrements; when it reaches 0, next RUN.
  - A new ex_branch_taken in FLUSH reloads flush_cnt to FLUSH_CYCLES-1.
- DWAIT:
  - While !dmem_ready: all en = 0, flushes 0; wait_cnt increments, saturating at TIMEOUT.
  - When wait_cnt == TIMEOUT, mem_timeout <= 1; it stays set until reset.
  - ex_branch_taken and load-use are ignored while frozen; EX holds, so they remain valid at release.
  - Release cycle (dmem_ready = 1): outputs evaluated exactly as the return state with the D-side rule false; next state per that evaluation; wait_cnt <= 0.
- dmem_req & dmem_ready in the same RUN cycle: no stall.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each non-reset cycle with pc_en == 0.
  - flush_events increments on each cycle where ex_branch_taken triggers a flush.
  - Both 32-bit, wrap at 2^32, cleared by reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset 3 cycles then release → during reset all en = 0, flushes = 1; first cycle after release all en = 1, flush = 0, mem_timeout = 0.
- ex_mem_read = 1, ex_rd = 5, id_use_rs2 = 1, id_rs2 = 5 → exactly one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; ex_rd = 0 with id_rs1 = 0 → no stall.
- FLUSH_CYCLES = 3, ex_branch_taken pulse → ifid_flush = idex_flush = 1 for 3 consecutive cycles, then RUN; flush_events = 1 with PIPE_PERF_CNT_EN.
- dmem_req = 1, dmem_ready low 4 cycles with ex_branch_taken = 1 held → all en = 0 for 4 cycles; on the release cycle the branch flush is applied; stall_cycles = 4.
- TIMEOUT = 8, dmem_ready held 0 for 10 cycles → mem_timeout rises after the 8th wait cycle and stays 1 after dmem_ready; clears only on reset.
- Reset asserted mid-DWAIT → next cycle state RUN, wait_cnt = 0, mem_timeout = 0, with no release-cycle enables seen.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, branch flush, I/D-side waits.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DWAIT} state_t;

  state_t        state_reg, state_next;
  state_t        ret_reg, ret_next;
  state_t        eval_state;
  logic [FW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          mem_timeout_reg;
  logic          load_use;
  logic          frozen;
  logic          wait_hit;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // A release cycle out of DWAIT behaves exactly like the state we froze in.
  assign eval_state = (state_reg == DWAIT) ? ret_reg : state_reg;
  assign frozen     = (state_reg == DWAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    state_next     = state_reg;
    ret_next       = ret_reg;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    wait_hit       = 1'b0;

    if (frozen) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      if (state_reg == DWAIT) begin
        wait_cnt_next = (wait_cnt_reg == WW'(TIMEOUT)) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
      end else begin
        state_next    = DWAIT;
        ret_next      = state_reg;
        wait_cnt_next = WW'(1);
      end
      wait_hit = (wait_cnt_next == WW'(TIMEOUT));
    end else begin
      if (state_reg == DWAIT) begin
        wait_cnt_next = '0;
      end
      if (eval_state == FLUSH) begin
        pc_en      = imem_ready;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (ex_branch_taken) begin
          flush_cnt_next = FW'(FLUSH_CYCLES - 1);
          state_next     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (flush_cnt_reg <= FW'(1)) begin
          flush_cnt_next = '0;
          state_next     = RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
          state_next     = FLUSH;
        end
      end else begin
        state_next = RUN;
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = FW'(FLUSH_CYCLES - 1);
          end
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    end

    if (reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      ret_reg         <= RUN;
      flush_cnt_reg   <= '0;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ret_reg       <= ret_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      if (wait_hit) begin
        mem_timeout_reg <= 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_events_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (!pc_en) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      // Branches seen while frozen are not counted; they are counted at release.
      if (ex_branch_taken && !frozen) begin
        flush_events_reg <= flush_events_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [6:0]  outs;

  int total = 0;
  int bad   = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected outs vectors: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [31:0] O_RST  = 32'b0000011;
  localparam logic [31:0] O_RUN  = 32'b1111100;
  localparam logic [31:0] O_LU   = 32'b0011101;
  localparam logic [31:0] O_IMEM = 32'b0111110;
  localparam logic [31:0] O_FL   = 32'b1111111;
  localparam logic [31:0] O_FLNI = 32'b0111111;
  localparam logic [31:0] O_FRZ  = 32'b0000000;

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to the next cycle's drive point (inputs change on the falling edge).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] st, input logic [31:0] fl);
    check_val({tag, "_stall"}, stall_cycles, PERF ? st : 32'd0);
    check_val({tag, "_flush"}, flush_events, PERF ? fl : 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      next_cycle(); settle();
      check_val("reset_outs", 32'(outs), O_RST);
    end

    next_cycle(); reset = 1'b0; settle();
    check_val("post_reset_outs", 32'(outs), O_RUN);
    check_val("post_reset_timeout", 32'(mem_timeout), 32'd0);
    check_perf("post_reset", 32'd0, 32'd0);

    // Load-use on rs2, then the load has moved on.
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5; settle();
    check_val("load_use_rs2", 32'(outs), O_LU);
    next_cycle(); ex_mem_read = 1'b0; settle();
    check_val("load_use_clear", 32'(outs), O_RUN);
    // x0 destination never stalls.
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0; settle();
    check_val("load_use_x0", 32'(outs), O_RUN);
    // Matching rs1 that is not read does not stall.
    next_cycle(); ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; settle();
    check_val("load_use_unused", 32'(outs), O_RUN);
    next_cycle(); ex_mem_read = 1'b0; imem_ready = 1'b0; settle();
    check_val("imem_wait", 32'(outs), O_IMEM);

    // Branch: three flush cycles, middle one with fetch not ready.
    next_cycle(); imem_ready = 1'b1; ex_branch_taken = 1'b1; settle();
    check_val("br_flush1", 32'(outs), O_FL);
    next_cycle(); ex_branch_taken = 1'b0; imem_ready = 1'b0; settle();
    check_val("br_flush2", 32'(outs), O_FLNI);
    next_cycle(); imem_ready = 1'b1; settle();
    check_val("br_flush3", 32'(outs), O_FL);
    next_cycle(); settle();
    check_val("br_done", 32'(outs), O_RUN);
    check_perf("br", 32'd3, 32'd1);

    // Second branch during FLUSH reloads the count.
    next_cycle(); ex_branch_taken = 1'b1; settle();
    check_val("reload_f1", 32'(outs), O_FL);
    next_cycle(); settle();
    check_val("reload_f2", 32'(outs), O_FL);
    next_cycle(); ex_branch_taken = 1'b0; settle();
    check_val("reload_f3", 32'(outs), O_FL);
    next_cycle(); settle();
    check_val("reload_f4", 32'(outs), O_FL);
    next_cycle(); settle();
    check_val("reload_done", 32'(outs), O_RUN);
    check_perf("reload", 32'd3, 32'd3);

    // D-side wait for 4 cycles with a branch held; flush applied on release.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1; settle();
      check_val("dwait_frozen", 32'(outs), O_FRZ);
    end
    next_cycle(); dmem_ready = 1'b1; settle();
    check_val("dwait_release_br", 32'(outs), O_FL);
    next_cycle(); dmem_req = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0; settle();
    check_val("dwait_post_f2", 32'(outs), O_FL);
    check_perf("dwait", 32'd7, 32'd4);
    next_cycle(); settle();
    check_val("dwait_post_f3", 32'(outs), O_FL);
    next_cycle(); settle();
    check_val("dwait_post_run", 32'(outs), O_RUN);
    check_val("dwait_no_timeout", 32'(mem_timeout), 32'd0);

    // Timeout: 10 wait cycles, flag visible from the 9th cycle on.
    for (int k = 1; k <= 10; k++) begin
      next_cycle(); dmem_req = 1'b1; dmem_ready = 1'b0; settle();
      check_val($sformatf("tmo_frozen_%0d", k), 32'(outs), O_FRZ);
      check_val($sformatf("tmo_flag_%0d", k), 32'(mem_timeout), (k > 8) ? 32'd1 : 32'd0);
    end
    next_cycle(); dmem_ready = 1'b1; settle();
    check_val("tmo_release", 32'(outs), O_RUN);
    next_cycle(); dmem_req = 1'b0; dmem_ready = 1'b0; settle();
    check_val("tmo_sticky", 32'(mem_timeout), 32'd1);
    check_perf("tmo", 32'd17, 32'd4);

    // Access that completes in the same cycle it is requested: no stall.
    next_cycle(); dmem_req = 1'b1; dmem_ready = 1'b1; settle();
    check_val("dmem_hit", 32'(outs), O_RUN);

    // Reset in the middle of DWAIT.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); dmem_req = 1'b1; dmem_ready = 1'b0; settle();
      check_val("mid_dwait", 32'(outs), O_FRZ);
    end
    next_cycle(); settle();
    check_perf("pre_reset", 32'd19, 32'd4);
    reset = 1'b1; dmem_ready = 1'b1; settle();
    check_val("mid_reset_outs", 32'(outs), O_RST);
    next_cycle(); reset = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; settle();
    check_val("after_reset_run", 32'(outs), O_RUN);
    check_val("after_reset_timeout", 32'(mem_timeout), 32'd0);
    check_perf("after_reset", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
